// File: rtl/alu_stream.sv
// Streaming registered ALU: operands in on a valid/ready beat, results with {V,C,N,Z} flags
// out through a DEPTH-entry in-order queue, plus a carry register for multi-word add chains.
module alu_stream #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [3:0]       in_sel,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [3:0]       out_flags,
   output logic             carry_q
);

   localparam int SW = $clog2(WIDTH);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int EW = WIDTH + 4;

   localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1'b1);
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [SW:0]   AMT_W    = (SW + 1)'(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3;
   localparam logic [3:0] OP_XOR  = 4'd4,  OP_NOT  = 4'd5,  OP_SHL  = 4'd6,  OP_SHR  = 4'd7;
   localparam logic [3:0] OP_SRA  = 4'd8,  OP_ROL  = 4'd9,  OP_ROR  = 4'd10, OP_SLT  = 4'd11;
   localparam logic [3:0] OP_SLTU = 4'd12, OP_MUL  = 4'd13, OP_ADDC = 4'd14, OP_PASS = 4'd15;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? {PW{1'b0}} : p + PTR_ONE;
   endfunction

   logic [EW-1:0]      mem_r [DEPTH];
   logic [PW-1:0]      rd_ptr_r, wr_ptr_r;
   logic [CW-1:0]      count_r;
   logic               carry_r;

   logic [SW-1:0]      amt_s;
   logic               amt_nz_s, cin_s, c_s, v_s, push_s, pop_s;
   logic [WIDTH:0]     sum_s, diff_s, shl_s, shr_s, sra_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   rol_s, ror_s, res_s;
   logic [3:0]         flags_s;
   logic [EW-1:0]      head_s;

   // Operation datapath and flag generation for the beat currently offered.
   always_comb begin
      amt_s    = in_b[SW-1:0];
      amt_nz_s = (amt_s != {SW{1'b0}});
      cin_s    = (in_sel == OP_ADDC) ? carry_r : 1'b0;
      sum_s    = {1'b0, in_a} + {1'b0, in_b} + {{WIDTH{1'b0}}, cin_s};
      diff_s   = {1'b0, in_a} - {1'b0, in_b};
      prod_s   = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
      // Extra bit beside the operand captures the last bit shifted out (zero for amount 0).
      shl_s    = {1'b0, in_a} << amt_s;
      shr_s    = {in_a, 1'b0} >> amt_s;
      sra_s    = $unsigned($signed({in_a, 1'b0}) >>> amt_s);
      rol_s    = (in_a << amt_s) | (in_a >> (AMT_W - {1'b0, amt_s}));
      ror_s    = (in_a >> amt_s) | (in_a << (AMT_W - {1'b0, amt_s}));
      res_s    = {WIDTH{1'b0}};
      c_s      = 1'b0;
      v_s      = 1'b0;
      case (in_sel)
         OP_ADD, OP_ADDC: begin
            res_s = sum_s[WIDTH-1:0];
            c_s   = sum_s[WIDTH];
            v_s   = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (res_s[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_SUB: begin
            res_s = diff_s[WIDTH-1:0];
            c_s   = diff_s[WIDTH];
            v_s   = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (res_s[WIDTH-1] != in_a[WIDTH-1]);
         end
         OP_AND:  res_s = in_a & in_b;
         OP_OR:   res_s = in_a | in_b;
         OP_XOR:  res_s = in_a ^ in_b;
         OP_NOT:  res_s = ~in_a;
         OP_SHL: begin
            res_s = shl_s[WIDTH-1:0];
            c_s   = shl_s[WIDTH];
         end
         OP_SHR: begin
            res_s = shr_s[WIDTH:1];
            c_s   = shr_s[0];
         end
         OP_SRA: begin
            res_s = sra_s[WIDTH:1];
            c_s   = sra_s[0];
         end
         OP_ROL: begin
            res_s = rol_s;
            c_s   = amt_nz_s & rol_s[0];
         end
         OP_ROR: begin
            res_s = ror_s;
            c_s   = amt_nz_s & ror_s[WIDTH-1];
         end
         OP_SLT:  res_s = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
         OP_SLTU: res_s = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
         OP_MUL: begin
            res_s = prod_s[WIDTH-1:0];
            c_s   = |prod_s[2*WIDTH-1:WIDTH];
         end
         OP_PASS: res_s = in_b;
         default: res_s = {WIDTH{1'b0}};
      endcase
      flags_s = {v_s, c_s, res_s[WIDTH-1], (res_s == {WIDTH{1'b0}})};
   end

   assign in_ready = rst_n & ~flush & (count_r != CNT_FULL);
   assign push_s   = in_valid & in_ready;
   assign pop_s    = out_valid & out_ready;

   // Result queue, pointers and carry register; flush clears everything except stored data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_r[i] <= {EW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         carry_r  <= 1'b0;
      end else if (flush) begin
         rd_ptr_r <= {PW{1'b0}};
         wr_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
         carry_r  <= 1'b0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= {flags_s, res_s};
            wr_ptr_r        <= ptr_next(wr_ptr_r);
            carry_r         <= c_s;
         end
         if (pop_s) rd_ptr_r <= ptr_next(rd_ptr_r);
         if (push_s && !pop_s)      count_r <= count_r + CNT_ONE;
         else if (pop_s && !push_s) count_r <= count_r - CNT_ONE;
         else                       count_r <= count_r;
      end
   end

   assign head_s     = mem_r[rd_ptr_r];
   assign out_valid  = (count_r != {CW{1'b0}});
   assign out_result = out_valid ? head_s[WIDTH-1:0] : {WIDTH{1'b0}};
   assign out_flags  = out_valid ? head_s[EW-1:WIDTH] : 4'd0;
   assign carry_q    = carry_r;

endmodule

// File: tb/tb_alu_stream.sv
// Bench for alu_stream: directed vector table, hand-written handshake/flush/reset sequences,
// and a random run scored against an arithmetic reference model with a result queue.
module tb_alu_stream;
   localparam int W = 8;
   localparam int D = 2;

   logic       clk = 1'b0;
   logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready, carry_q;
   logic [7:0] in_a, in_b, out_result;
   logic [3:0] in_sel, out_flags;

   int total = 0;
   int bad   = 0;

   alu_stream #(.WIDTH(W), .DEPTH(D)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
      .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
      .out_flags(out_flags), .carry_q(carry_q)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: returns {V,C,N,Z,result} from plain integer arithmetic.
   function automatic logic [11:0] model(input int a, input int b, input int sel, input int cin);
      int sa, sb, amt, r, c, v, t;
      sa = (a >= 128) ? a - 256 : a;
      sb = (b >= 128) ? b - 256 : b;
      amt = b % W;
      r = 0; c = 0; v = 0;
      case (sel)
         0, 14: begin
            if (sel == 0) cin = 0;
            t = a + b + cin; r = t & 255; c = t >> 8;
            v = (sa + sb + cin > 127 || sa + sb + cin < -128) ? 1 : 0;
         end
         1: begin
            r = (a - b) & 255; c = (a < b) ? 1 : 0;
            v = (sa - sb > 127 || sa - sb < -128) ? 1 : 0;
         end
         2: r = a & b;
         3: r = a | b;
         4: r = a ^ b;
         5: r = (~a) & 255;
         6: begin r = (a << amt) & 255; c = (amt != 0) ? (a >> (8 - amt)) & 1 : 0; end
         7: begin r = a >> amt; c = (amt != 0) ? (a >> (amt - 1)) & 1 : 0; end
         8: begin r = (sa >>> amt) & 255; c = (amt != 0) ? (a >> (amt - 1)) & 1 : 0; end
         9: begin
            r = a;
            repeat (amt) begin c = (r >> 7) & 1; r = ((r << 1) | c) & 255; end
         end
         10: begin
            r = a;
            repeat (amt) begin c = r & 1; r = (r >> 1) | (c << 7); end
         end
         11: r = (sa < sb) ? 1 : 0;
         12: r = (a < b) ? 1 : 0;
         13: begin t = a * b; r = t & 255; c = ((t >> 8) != 0) ? 1 : 0; end
         default: r = b;
      endcase
      return {v != 0, c != 0, r[7], r[7:0] == 8'd0, r[7:0]};
   endfunction

   typedef struct {
      logic [3:0] sel;
      logic [7:0] a, b, res;
      logic [3:0] flags;
   } vec_t;

   vec_t       tbl[15];
   logic [11:0] q[$];
   logic [11:0] e;
   logic [11:0] bp_exp[3];
   int          m_carry;
   logic        acc, pop;

   task automatic beat(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
      @(negedge clk);
      in_valid = 1'b1; in_sel = s; in_a = a; in_b = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 4'b0101};
      tbl[1]  = '{4'd14, 8'h00, 8'h00, 8'h01, 4'b0000};
      tbl[2]  = '{4'd1,  8'h80, 8'h01, 8'h7F, 4'b1000};
      tbl[3]  = '{4'd1,  8'h01, 8'h02, 8'hFF, 4'b0110};
      tbl[4]  = '{4'd8,  8'h90, 8'h02, 8'hE4, 4'b0010};
      tbl[5]  = '{4'd9,  8'h81, 8'h01, 8'h03, 4'b0100};
      tbl[6]  = '{4'd6,  8'h5A, 8'h00, 8'h5A, 4'b0000};
      tbl[7]  = '{4'd13, 8'h10, 8'h10, 8'h00, 4'b0101};
      tbl[8]  = '{4'd11, 8'h80, 8'h01, 8'h01, 4'b0000};
      tbl[9]  = '{4'd12, 8'h80, 8'h01, 8'h00, 4'b0001};
      tbl[10] = '{4'd10, 8'h01, 8'h01, 8'h80, 4'b0110};
      tbl[11] = '{4'd7,  8'h81, 8'h03, 8'h10, 4'b0000};
      tbl[12] = '{4'd0,  8'h7F, 8'h01, 8'h80, 4'b1010};
      tbl[13] = '{4'd5,  8'h0F, 8'h33, 8'hF0, 4'b0010};
      tbl[14] = '{4'd15, 8'h00, 8'h00, 8'h00, 4'b0001};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_a = 8'h00; in_b = 8'h00; in_sel = 4'd0;
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_carry", carry_q, 0);
      chk("rst_result", out_result, 0);
      chk("rst_flags", out_flags, 0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_in_ready", in_ready, 1);

      // Directed table, one beat at a time with the consumer always ready.
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         beat(tbl[i].sel, tbl[i].a, tbl[i].b);
         chk($sformatf("tbl%0d_valid", i), out_valid, 1);
         chk($sformatf("tbl%0d_result", i), out_result, tbl[i].res);
         chk($sformatf("tbl%0d_flags", i), out_flags, tbl[i].flags);
         chk($sformatf("tbl%0d_carry", i), carry_q, tbl[i].flags[2]);
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_popped", i), out_valid, 0);
      end

      // Backpressure: two beats fill the queue, the third waits for the first pop.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) bp_exp[i] = model(i + 1, 8'h10, 0, 0);
      beat(4'd0, 8'h01, 8'h10);
      beat(4'd0, 8'h02, 8'h10);
      @(negedge clk);
      in_valid = 1'b1; in_sel = 4'd0; in_a = 8'h03; in_b = 8'h10;
      chk("bp_full_ready", in_ready, 0);
      repeat (2) @(negedge clk);
      chk("bp_stall_ready", in_ready, 0);
      chk("bp_stall_result", {out_flags, out_result}, bp_exp[0]);
      out_ready = 1'b1; #1;
      chk("bp_no_comb_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("bp_pop1_ready", in_ready, 1);
      chk("bp_head2", {out_flags, out_result}, bp_exp[1]);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_head3", {out_flags, out_result}, bp_exp[2]);
      @(posedge clk); #1;
      chk("bp_drained", out_valid, 0);

      // Flush with two entries queued and a beat offered.
      out_ready = 1'b0;
      beat(4'd0, 8'hFF, 8'h01);
      beat(4'd0, 8'hFF, 8'h01);
      @(negedge clk);
      flush = 1'b1; in_valid = 1'b1; in_sel = 4'd0; in_a = 8'h05; in_b = 8'h05;
      #1;
      chk("fl_ready", in_ready, 0);
      chk("fl_carry_before", carry_q, 1);
      @(posedge clk); #1;
      chk("fl_valid", out_valid, 0);
      chk("fl_carry", carry_q, 0);
      @(negedge clk) begin flush = 1'b0; in_valid = 1'b0; end
      @(posedge clk); #1;
      chk("fl_not_accepted", out_valid, 0);

      // Asynchronous reset with a full queue.
      beat(4'd0, 8'hFF, 8'h01);
      beat(4'd0, 8'hFF, 8'h01);
      @(negedge clk); #2;
      rst_n = 1'b0; #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_carry", carry_q, 0);
      chk("ar_result", out_result, 0);
      chk("ar_ready", in_ready, 0);
      @(negedge clk) rst_n = 1'b1;
      out_ready = 1'b1;
      beat(4'd1, 8'h01, 8'h02);
      chk("ar_resume", {out_flags, out_result}, 12'h6FF);
      @(negedge clk) flush = 1'b1;
      @(negedge clk) flush = 1'b0;

      // Random traffic against the reference queue.
      m_carry = 0;
      q.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 40) == 0);
         in_sel    = 4'($urandom_range(0, 15));
         in_a      = 8'($urandom);
         in_b      = 8'($urandom);
         #1;
         chk("rnd_in_ready", in_ready, (!flush && q.size() < D));
         chk("rnd_out_valid", out_valid, (q.size() != 0));
         chk("rnd_carry", carry_q, m_carry);
         if (q.size() != 0) chk("rnd_head", {out_flags, out_result}, q[0]);
         else               chk("rnd_idle_out", {out_flags, out_result}, 0);
         acc = in_valid && in_ready;
         pop = out_valid && out_ready;
         @(posedge clk);
         if (flush) begin
            q.delete();
            m_carry = 0;
         end else begin
            if (pop && q.size() != 0) void'(q.pop_front());
            if (acc) begin
               e = model(in_a, in_b, in_sel, m_carry);
               q.push_back(e);
               m_carry = e[10];
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
